axi4_write_arbiter: RTL and testbench

//  Shares one AXI4 write slave port (AW/W/B) between NUM_MASTERS requesters.
//  - AW: round-robin arbitration.
//  - W: locked to the granted master until WLAST.
//  - B: each response is routed back through an in-order grant FIFO.

---
 rtl/axi4_write_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_axi4_write_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_write_arbiter.sv
// rtl/axi4_write_arbiter.sv - round-robin AXI4 write-channel arbiter with in-order B routing
//
// Purpose:
//   Shares one AXI4 write slave port (AW/W/B) between NUM_MASTERS requesters.
//   AW is arbitrated round-robin, W stays locked to the granted master until
//   WLAST, and B responses are routed back through an in-order grant FIFO.
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   s_aw_payload/valid/ready       per-master AW channel (master i at slice i)
//   s_w_payload/last/valid/ready   per-master W channel
//   s_b_payload                    B fields, broadcast to every master
//   s_b_valid/ready                per-master B handshake
//   m_aw_payload/valid/ready       slave-side AW channel
//   m_w_payload/last/valid/ready   slave-side W channel
//   m_b_payload/valid/ready        slave-side B channel
//   outstanding                    bursts whose B response is still pending
//   b_unexpected                   pulse: slave offered a B while nothing was pending

module axi4_write_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int USER_WIDTH      = 1,
  parameter int MAX_OUTSTANDING = 4,
  localparam int AW_PW = ID_WIDTH + ADDR_WIDTH + 8 + 2 + 1 + 4 + 3 + 4 + 4 + USER_WIDTH,
  localparam int W_PW  = DATA_WIDTH + DATA_WIDTH / 8 + USER_WIDTH,
  localparam int B_PW  = ID_WIDTH + 2 + USER_WIDTH,
  localparam int IW    = $clog2(NUM_MASTERS),
  localparam int CW    = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [NUM_MASTERS*AW_PW-1:0] s_aw_payload,
  input  logic [NUM_MASTERS-1:0]       s_aw_valid,
  output logic [NUM_MASTERS-1:0]       s_aw_ready,

  input  logic [NUM_MASTERS*W_PW-1:0]  s_w_payload,
  input  logic [NUM_MASTERS-1:0]       s_w_last,
  input  logic [NUM_MASTERS-1:0]       s_w_valid,
  output logic [NUM_MASTERS-1:0]       s_w_ready,

  output logic [B_PW-1:0]              s_b_payload,
  output logic [NUM_MASTERS-1:0]       s_b_valid,
  input  logic [NUM_MASTERS-1:0]       s_b_ready,

  output logic [AW_PW-1:0]             m_aw_payload,
  output logic                         m_aw_valid,
  input  logic                         m_aw_ready,

  output logic [W_PW-1:0]              m_w_payload,
  output logic                         m_w_last,
  output logic                         m_w_valid,
  input  logic                         m_w_ready,

  input  logic [B_PW-1:0]              m_b_payload,
  input  logic                         m_b_valid,
  output logic                         m_b_ready,

  output logic [CW-1:0]                outstanding,
  output logic                         b_unexpected
);

  localparam int PW = $clog2(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0] grant;
  logic [IW-1:0] last_grant;
  logic          grant_load;

  logic [IW-1:0] rr_pick;
  logic [IW-1:0] rr_cand;
  logic          rr_found;

  logic          push;
  logic          pop;

  logic [IW-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic [IW-1:0] head;

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan masters starting just after the last winner, so the
  // reset value last_grant = N-1 makes master 0 the first winner.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (int'(last_grant) + k >= NUM_MASTERS) begin
        rr_cand = IW'(int'(last_grant) + k - NUM_MASTERS);
      end else begin
        rr_cand = IW'(int'(last_grant) + k);
      end
      if (!rr_found && s_aw_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nx;
      if (grant_load) begin
        grant      <= rr_pick;
        last_grant <= rr_pick;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration FSM: next state and AW/W datapath steering.
  // Payload muxes always follow the registered grant; they are only meaningful
  // while the matching valid is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx     = state;
    grant_load   = 1'b0;
    push         = 1'b0;
    m_aw_payload = s_aw_payload[int'(grant)*AW_PW +: AW_PW];
    m_aw_valid   = 1'b0;
    s_aw_ready   = '0;
    m_w_payload  = s_w_payload[int'(grant)*W_PW +: W_PW];
    m_w_last     = s_w_last[grant];
    m_w_valid    = 1'b0;
    s_w_ready    = '0;

    case (state)
      ST_IDLE: begin
        // The FIFO fullness check here is sufficient: between this grant and
        // the push in ST_AW nothing else can push, so the slot stays reserved.
        if (|s_aw_valid && !fifo_full) begin
          grant_load = 1'b1;
          state_nx   = ST_AW;
        end
      end

      ST_AW: begin
        m_aw_valid        = s_aw_valid[grant];
        s_aw_ready[grant] = m_aw_ready;
        if (s_aw_valid[grant] && m_aw_ready) begin
          push     = 1'b1;
          state_nx = ST_W;
        end
      end

      ST_W: begin
        m_w_valid        = s_w_valid[grant];
        s_w_ready[grant] = m_w_ready;
        if (s_w_valid[grant] && m_w_ready && s_w_last[grant]) begin
          state_nx = ST_IDLE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // B routing FIFO: holds the master index of every AW burst issued, in order.
  // The head entry decides which master sees the next B response.
  // ---------------------------------------------------------------------------
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CW'(MAX_OUTSTANDING));
  assign head        = fifo_mem[rd_ptr];
  assign outstanding = count;
  assign s_b_payload = m_b_payload;

  always_comb begin
    s_b_valid = '0;
    m_b_ready = 1'b0;
    pop       = 1'b0;
    if (!fifo_empty) begin
      s_b_valid[head] = m_b_valid;
      m_b_ready       = s_b_ready[head];
      pop             = m_b_valid && s_b_ready[head];
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= grant;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      b_unexpected <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      b_unexpected <= m_b_valid && fifo_empty;
    end
  end

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// tb/tb_axi4_write_arbiter.sv - directed self-checking bench for axi4_write_arbiter

module tb_axi4_write_arbiter;

  localparam int N     = 2;
  localparam int AW_PW = 4 + 32 + 8 + 2 + 1 + 4 + 3 + 4 + 4 + 1;
  localparam int W_PW  = 32 + 4 + 1;
  localparam int B_PW  = 4 + 2 + 1;
  localparam int CW    = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N*AW_PW-1:0]   s_aw_payload;
  logic [N-1:0]         s_aw_valid;
  logic [N-1:0]         s_aw_ready;
  logic [N*W_PW-1:0]    s_w_payload;
  logic [N-1:0]         s_w_last;
  logic [N-1:0]         s_w_valid;
  logic [N-1:0]         s_w_ready;
  logic [B_PW-1:0]      s_b_payload;
  logic [N-1:0]         s_b_valid;
  logic [N-1:0]         s_b_ready;
  logic [AW_PW-1:0]     m_aw_payload;
  logic                 m_aw_valid;
  logic                 m_aw_ready;
  logic [W_PW-1:0]      m_w_payload;
  logic                 m_w_last;
  logic                 m_w_valid;
  logic                 m_w_ready;
  logic [B_PW-1:0]      m_b_payload;
  logic                 m_b_valid;
  logic                 m_b_ready;
  logic [CW-1:0]        outstanding;
  logic                 b_unexpected;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi4_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .s_aw_payload (s_aw_payload),
    .s_aw_valid   (s_aw_valid),
    .s_aw_ready   (s_aw_ready),
    .s_w_payload  (s_w_payload),
    .s_w_last     (s_w_last),
    .s_w_valid    (s_w_valid),
    .s_w_ready    (s_w_ready),
    .s_b_payload  (s_b_payload),
    .s_b_valid    (s_b_valid),
    .s_b_ready    (s_b_ready),
    .m_aw_payload (m_aw_payload),
    .m_aw_valid   (m_aw_valid),
    .m_aw_ready   (m_aw_ready),
    .m_w_payload  (m_w_payload),
    .m_w_last     (m_w_last),
    .m_w_valid    (m_w_valid),
    .m_w_ready    (m_w_ready),
    .m_b_payload  (m_b_payload),
    .m_b_valid    (m_b_valid),
    .m_b_ready    (m_b_ready),
    .outstanding  (outstanding),
    .b_unexpected (b_unexpected)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW_PW-1:0] mk_aw(input logic [3:0] id, input logic [31:0] addr,
                                             input logic [7:0] len);
    return {id, addr, len, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 1'b0};
  endfunction

  function automatic logic [W_PW-1:0] mk_w(input logic [31:0] data);
    return {data, 4'hF, 1'b0};
  endfunction

  function automatic logic [B_PW-1:0] mk_b(input logic [3:0] id, input logic [1:0] resp);
    return {id, resp, 1'b0};
  endfunction

  task automatic clear_inputs();
    s_aw_payload = '0;
    s_aw_valid   = '0;
    s_w_payload  = '0;
    s_w_last     = '0;
    s_w_valid    = '0;
    s_b_ready    = '0;
    m_aw_ready   = 1'b0;
    m_w_ready    = 1'b0;
    m_b_payload  = '0;
    m_b_valid    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset state
    @(negedge clk); #1;
    check("rst_m_aw_valid", m_aw_valid, 0);
    check("rst_s_aw_ready", s_aw_ready, 0);
    check("rst_s_w_ready", s_w_ready, 0);
    check("rst_m_b_ready", m_b_ready, 0);
    check("rst_s_b_valid", s_b_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_b_unexpected", b_unexpected, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: single master, len=3, 4 beats, BID=2
    @(negedge clk);
    s_aw_valid = 2'b01;
    s_aw_payload[0 +: AW_PW] = mk_aw(4'h2, 32'h0000_1000, 8'd3);
    m_aw_ready = 1'b1;
    #1 check("t1_aw_latency", m_aw_valid, 0);
    @(negedge clk); #1;
    check("t1_aw_valid", m_aw_valid, 1);
    check("t1_aw_ready", s_aw_ready, 2'b01);
    check("t1_aw_payload", m_aw_payload, mk_aw(4'h2, 32'h0000_1000, 8'd3));
    @(negedge clk);
    s_aw_valid = '0;
    m_w_ready  = 1'b1;
    s_w_valid  = 2'b01;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      s_w_payload[0 +: W_PW] = mk_w(32'hA0 + 32'(i));
      s_w_last = (i == 3) ? 2'b01 : 2'b00;
      #1;
      check("t1_w_payload", m_w_payload, mk_w(32'hA0 + 32'(i)));
      check("t1_w_last", m_w_last, (i == 3) ? 1 : 0);
      check("t1_w_ready", s_w_ready, 2'b01);
      if (i == 0) check("t1_outstanding_1", outstanding, 1);
    end
    @(negedge clk);
    s_w_valid = '0;
    s_w_last  = '0;
    m_b_payload = mk_b(4'h2, 2'b00);
    m_b_valid   = 1'b1;
    s_b_ready   = 2'b01;
    #1;
    check("t1_w_done", m_w_valid, 0);
    check("t1_b_valid", s_b_valid, 2'b01);
    check("t1_b_ready", m_b_ready, 1);
    check("t1_b_payload", s_b_payload, mk_b(4'h2, 2'b00));
    @(negedge clk);
    m_b_valid = 1'b0;
    #1;
    check("t1_outstanding_0", outstanding, 0);
    check("t1_no_unexpected", b_unexpected, 0);

    // Test 2: simultaneous requests after reset, round-robin order
    do_reset();
    @(negedge clk);
    s_aw_valid = 2'b11;
    s_aw_payload[0 +: AW_PW]     = mk_aw(4'h1, 32'h0000_2000, 8'd0);
    s_aw_payload[AW_PW +: AW_PW] = mk_aw(4'h3, 32'h0000_3000, 8'd0);
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    @(negedge clk); #1;
    check("t2_first_m0", s_aw_ready, 2'b01);
    check("t2_first_payload", m_aw_payload, mk_aw(4'h1, 32'h0000_2000, 8'd0));
    @(negedge clk);
    s_aw_valid = 2'b10;
    s_w_valid  = 2'b01;
    s_w_last   = 2'b01;
    s_w_payload[0 +: W_PW] = mk_w(32'h1111_0000);
    #1;
    check("t2_m1_waits", s_aw_ready, 2'b00);
    check("t2_m0_w_ready", s_w_ready, 2'b01);
    @(negedge clk);
    s_w_valid = '0;
    s_w_last  = '0;
    #1 check("t2_bubble", s_aw_ready, 2'b00);
    @(negedge clk); #1;
    check("t2_second_m1", s_aw_ready, 2'b10);
    check("t2_second_payload", m_aw_payload, mk_aw(4'h3, 32'h0000_3000, 8'd0));
    @(negedge clk);
    s_aw_valid = '0;
    s_w_valid  = 2'b10;
    s_w_last   = 2'b10;
    s_w_payload[W_PW +: W_PW] = mk_w(32'h2222_0000);
    #1 check("t2_m1_w_ready", s_w_ready, 2'b10);
    @(negedge clk);
    s_w_valid  = '0;
    s_w_last   = '0;
    s_aw_valid = 2'b11;
    @(negedge clk); #1;
    check("t2_rr_again_m0", s_aw_ready, 2'b01);
    @(negedge clk);
    s_aw_valid = '0;
    s_w_valid  = 2'b01;
    s_w_last   = 2'b01;
    #1 check("t2_m0_w_ready_2", s_w_ready, 2'b01);
    @(negedge clk);
    s_w_valid = '0;
    s_w_last  = '0;
    #1 check("t2_outstanding_3", outstanding, 3);

    // Test 5: B order m0,m1,m0 with m1 withholding BREADY for 5 cycles
    @(negedge clk);
    m_b_valid   = 1'b1;
    m_b_payload = mk_b(4'h1, 2'b00);
    s_b_ready   = 2'b01;
    #1;
    check("t5_b0_valid", s_b_valid, 2'b01);
    check("t5_b0_ready", m_b_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_b_payload = mk_b(4'h3, 2'b10);
      #1;
      check("t5_hold_valid", s_b_valid, 2'b10);
      check("t5_hold_ready", m_b_ready, 0);
    end
    check("t5_hold_outstanding", outstanding, 2);
    @(negedge clk);
    s_b_ready = 2'b11;
    #1;
    check("t5_b1_valid", s_b_valid, 2'b10);
    check("t5_b1_ready", m_b_ready, 1);
    check("t5_b1_payload", s_b_payload, mk_b(4'h3, 2'b10));
    @(negedge clk);
    m_b_payload = mk_b(4'h1, 2'b00);
    #1;
    check("t5_b2_valid", s_b_valid, 2'b01);
    check("t5_b2_ready", m_b_ready, 1);
    check("t5_outstanding_1", outstanding, 1);
    @(negedge clk); #1;
    check("t5_empty_valid", s_b_valid, 2'b00);
    check("t5_empty_ready", m_b_ready, 0);
    check("t5_outstanding_0", outstanding, 0);
    @(negedge clk);
    m_b_valid = 1'b0;
    #1 check("t5_unexpected_pulse", b_unexpected, 1);
    @(negedge clk); #1;
    check("t5_unexpected_clear", b_unexpected, 0);

    // Test 3: FIFO full blocks the 5th AW until a B pops
    do_reset();
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_aw_valid = 2'b01;
      s_aw_payload[0 +: AW_PW] = mk_aw(4'(i), 32'h0000_4000 + 32'(i * 16), 8'd0);
      @(negedge clk); #1;
      check("t3_aw_accept", s_aw_ready, 2'b01);
      @(negedge clk);
      s_aw_valid = '0;
      s_w_valid  = 2'b01;
      s_w_last   = 2'b01;
      @(negedge clk);
      s_w_valid = '0;
      s_w_last  = '0;
    end
    @(negedge clk);
    s_aw_valid = 2'b01;
    #1 check("t3_outstanding_4", outstanding, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t3_stall_ready", s_aw_ready, 2'b00);
      check("t3_stall_valid", m_aw_valid, 0);
    end
    @(negedge clk);
    m_b_valid   = 1'b1;
    m_b_payload = mk_b(4'h0, 2'b00);
    s_b_ready   = 2'b01;
    #1 check("t3_pop_ready", m_b_ready, 1);
    @(negedge clk);
    m_b_valid = 1'b0;
    #1;
    check("t3_outstanding_3", outstanding, 3);
    check("t3_still_idle", s_aw_ready, 2'b00);
    @(negedge clk); #1;
    check("t3_issue", s_aw_ready, 2'b01);

    // Test 4: m1 W presented before its AW while m0 bursts
    do_reset();
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    @(negedge clk);
    s_aw_valid = 2'b01;
    s_aw_payload[0 +: AW_PW] = mk_aw(4'h5, 32'h0000_5000, 8'd1);
    @(negedge clk); #1;
    check("t4_m0_aw", s_aw_ready, 2'b01);
    @(negedge clk);
    s_aw_valid = 2'b10;
    s_aw_payload[AW_PW +: AW_PW] = mk_aw(4'h6, 32'h0000_6000, 8'd1);
    s_w_valid = 2'b11;
    s_w_last  = 2'b00;
    s_w_payload[0 +: W_PW]    = mk_w(32'hAAAA_0000);
    s_w_payload[W_PW +: W_PW] = mk_w(32'hBBBB_0000);
    #1;
    check("t4_m1_w_blocked_0", s_w_ready, 2'b01);
    check("t4_m0_beat0", m_w_payload, mk_w(32'hAAAA_0000));
    @(negedge clk);
    s_w_last = 2'b01;
    s_w_payload[0 +: W_PW] = mk_w(32'hAAAA_0001);
    #1;
    check("t4_m1_w_blocked_1", s_w_ready, 2'b01);
    check("t4_m0_beat1", m_w_payload, mk_w(32'hAAAA_0001));
    @(negedge clk);
    s_w_valid = 2'b10;
    s_w_last  = 2'b00;
    #1 check("t4_idle_no_wready", s_w_ready, 2'b00);
    @(negedge clk); #1;
    check("t4_aw_no_wready", s_w_ready, 2'b00);
    check("t4_m1_aw", s_aw_ready, 2'b10);
    @(negedge clk);
    s_aw_valid = '0;
    #1;
    check("t4_m1_wready", s_w_ready, 2'b10);
    check("t4_m1_beat0", m_w_payload, mk_w(32'hBBBB_0000));
    check("t4_outstanding_2", outstanding, 2);

    // Test 6: reset asserted mid W burst with outstanding=2
    @(negedge clk);
    s_w_payload[W_PW +: W_PW] = mk_w(32'hBBBB_0001);
    s_w_last = 2'b10;
    #1 check("t6_pre_w_valid", m_w_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_w_valid", m_w_valid, 0);
    check("t6_rst_w_ready", s_w_ready, 2'b00);
    check("t6_rst_outstanding", outstanding, 0);
    check("t6_rst_aw_valid", m_aw_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    s_w_valid  = '0;
    s_w_last   = '0;
    s_aw_valid = 2'b11;
    #1 check("t6_outstanding_0", outstanding, 0);
    @(negedge clk); #1;
    check("t6_m0_priority", s_aw_ready, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
